icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped instruction cache between the pipeline's fetch side and the memory controller.
- Serves fetch requests with a combinational hit path (same-cycle ihit/imemload).
- On a miss, a small FSM fills one frame from memory.
- Feeds imemload/ihit into the IF/DC pipeline register; consumes imemREN/imemaddr from the PC stage.

Parameters:
- SETS, 16, number of one-word frames; power of two, at least 2.
- IDX_W, $clog2(SETS), index width.
- TAG_W, 30-IDX_W, tag width (addr[31:2+IDX_W]).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- imemREN  input  1  fetch request from datapath.
- imemaddr  input  32  fetch byte address; bits [1:0] ignored.
- flush  input  1  invalidate all frames.
- ihit  output  1  imemload valid this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  memory read request.
- iaddr  output  32  memory word address.
- iwait  input  1  memory busy; low = iload valid.
- iload  input  32  memory read data.

Behaviour:
- Address split:
  - idx = imemaddr[2+IDX_W-1:2]
  - tag = imemaddr[31:2+IDX_W]
  - iaddr is always {latched tag, latched idx, 2'b00}.
- Storage per frame: valid bit, TAG_W tag, 32-bit data.
- FSM states: IDLE, FILL.
- IDLE:
  - ihit = imemREN & ~flush & valid[idx] & (tagarr[idx]==tag).
  - imemload = data[idx] (driven regardless of hit).
  - iREN = 0.
  - If imemREN & ~ihit & ~flush: latch tag/idx, go to FILL.
- FILL:
  - iREN = 1, ihit = 0.
  - Abort to IDLE with no array write if any of these hold: flush, ~imemREN, or the current address's {tag,idx} differs from the latched value (branch redirect, or dmem access taking the bus).
  - Otherwise, when iwait=0: write data=iload, tag=latched, valid=1 into the latched frame, then go to IDLE.
- Latency: hit 0 extra cycles. Miss costs 1 detect cycle, then memory wait cycles, then 1 cycle; ihit rises the cycle after the fill write.
- The fill write and a hit never occur in the same cycle.
- flush in any state:
  - clears all valid bits at the next edge; state becomes IDLE.
  - ihit = 0 during the flush cycle.
- RST:
  - all valid = 0, state = IDLE, latched tag/idx = 0.
  - Outputs then read ihit=0, iREN=0, iaddr=0, imemload=data[idx] (contents don't care).
  - Reset mid-FILL discards the fill; iREN drops the next cycle.
- Conflict eviction: a new fill overwrites the frame unconditionally; no write-back (read-only cache).
- imemREN low in IDLE: ihit = 0, no state change.

Optional Feature:
- ICACHE_STATS_EN defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both saturating, cleared by RST; flush does not clear them.
  - hit_count increments on each cycle with ihit=1.
  - miss_count increments on each IDLE->FILL transition.
- Undefined: these ports and counters do not exist.

Decomposition:
- diaosi_types_pkg gains:
  - icache_state_t enum {IDLE, FILL}
  - icache_frame_t packed struct {valid, tag, data}
  - ICACHE_SETS constant = 16
- One sub-module, icache_frame_array: SETS-entry frame storage.
  - Read port: combinational.
  - Write port: synchronous, with a synchronous clear-all for RST/flush.
  - Parameters shared with the parent.

Test Plan:
- Cold miss: RST, imemREN=1, imemaddr=0x00000040, iwait high 3 cycles then low with iload=0x8C220004 -> iREN=1 with iaddr=0x00000040 for 4 cycles; next cycle ihit=1, imemload=0x8C220004.
- Repeat hit: after the cold miss, present 0x00000040 again -> ihit=1 same cycle, iREN=0.
- Conflict: fill 0x00000040, then request 0x00000080 (same idx=0, different tag) -> miss, refill; 0x00000040 then misses again.
- Redirect abort: in FILL for 0x00000100, change imemaddr to 0x00000200 before iwait falls -> no write to idx 0; new fill starts for 0x00000200 (iaddr=0x00000200).
- Flush: fill 0x00000004, assert flush one cycle -> ihit=0 that cycle; subsequent request for 0x00000004 misses.
- Stats (ICACHE_STATS_EN): cold miss, then 5 hit cycles -> miss_count=1, hit_count=5; RST -> both 0.

Source files
------------

// File: rtl/diaosi_types_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package diaosi_types_pkg;

   localparam int unsigned ICACHE_SETS  = 16;
   localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
   localparam int unsigned ICACHE_TAG_W = 30 - ICACHE_IDX_W;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

   typedef struct packed {
      logic                    valid;
      logic [ICACHE_TAG_W-1:0] tag;
      logic [31:0]             data;
   } icache_frame_t;

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage for the instruction cache: combinational read, synchronous
// write, synchronous clear-all of the valid bits.
module icache_frame_array
   import diaosi_types_pkg::*;
#(
   parameter int unsigned SETS  = ICACHE_SETS,
   parameter int unsigned IDX_W = $clog2(SETS),
   parameter int unsigned TAG_W = 30 - IDX_W
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [31:0]      wr_data
);

   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [31:0]      data_q [SETS];

   // Only the valid bits need clearing; tag/data are ignored while invalid.
   always_ff @(posedge clk) begin
      if (clear) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with a same-cycle hit path and a one-word
// fill FSM. Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_direct
   import diaosi_types_pkg::*;
#(
   parameter int unsigned SETS = ICACHE_SETS
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        flush,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 30 - IDX_W;

   icache_state_t    state;
   logic [TAG_W-1:0] lat_tag;
   logic [IDX_W-1:0] lat_idx;

   logic [IDX_W-1:0] cur_idx;
   logic [TAG_W-1:0] cur_tag;
   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [31:0]      rd_data;
   logic             lookup_hit;
   logic             start_fill;
   logic             fill_abort;
   logic             fill_write;
   logic             unused_addr_bits;

   assign cur_idx          = imemaddr[2+IDX_W-1:2];
   assign cur_tag          = imemaddr[31:2+IDX_W];
   assign unused_addr_bits = ^imemaddr[1:0];

   icache_frame_array #(
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_frames (
      .clk      (CLK),
      .clear    (RST | flush),
      .rd_idx   (cur_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (fill_write),
      .wr_idx   (lat_idx),
      .wr_tag   (lat_tag),
      .wr_data  (iload)
   );

   assign lookup_hit = rd_valid && (rd_tag == cur_tag);

   // Hit path and fill decisions; a fill write only happens in FILL, where ihit is 0.
   always_comb begin
      ihit       = 1'b0;
      iREN       = 1'b0;
      start_fill = 1'b0;
      fill_abort = 1'b0;
      fill_write = 1'b0;
      case (state)
         IDLE: begin
            ihit       = imemREN & ~flush & lookup_hit;
            start_fill = imemREN & ~flush & ~lookup_hit;
         end
         FILL: begin
            iREN       = 1'b1;
            fill_abort = flush | ~imemREN | ({cur_tag, cur_idx} != {lat_tag, lat_idx});
            fill_write = ~RST & ~fill_abort & ~iwait;
         end
         default: ;
      endcase
   end

   assign imemload = rd_data;
   assign iaddr    = {lat_tag, lat_idx, 2'b00};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         lat_tag <= '0;
         lat_idx <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_fill) begin
                  lat_tag <= cur_tag;
                  lat_idx <= cur_idx;
                  state   <= FILL;
               end
            end
            FILL: begin
               if (fill_abort || fill_write) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (ihit && (hit_count != '1)) begin
            hit_count <= hit_count + 32'(1);
         end
         if (start_fill && (miss_count != '1)) begin
            miss_count <= miss_count + 32'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct (optionally with ICACHE_STATS_EN).
module tb_icache_direct;

   logic        CLK;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        flush;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   icache_direct dut (
      .CLK        (CLK),
      .RST        (RST),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .flush      (flush),
      .ihit       (ihit),
      .imemload   (imemload),
      .iREN       (iREN),
      .iaddr      (iaddr),
      .iwait      (iwait),
      .iload      (iload)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      RST      = 1'b1;
      imemREN  = 1'b0;
      imemaddr = 32'h0;
      flush    = 1'b0;
      iwait    = 1'b1;
      iload    = 32'h0;
      tick();
      tick();
      chk("rst_ihit",  32'(ihit), 32'h0);
      chk("rst_iren",  32'(iREN), 32'h0);
      chk("rst_iaddr", iaddr,     32'h0);

      // Cold miss at 0x40: detect cycle, then 3 wait cycles and 1 data cycle.
      RST      = 1'b0;
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0040;
      #1;
      chk("cold_detect_ihit", 32'(ihit), 32'h0);
      chk("cold_detect_iren", 32'(iREN), 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            iwait = 1'b0;
            iload = 32'h8C22_0004;
         end
         #1;
         chk("cold_fill_iren",  32'(iREN), 32'h1);
         chk("cold_fill_iaddr", iaddr,     32'h0000_0040);
         chk("cold_fill_ihit",  32'(ihit), 32'h0);
         tick();
      end
      iwait = 1'b1;
      iload = 32'h0;
      #1;
      chk("cold_after_ihit", 32'(ihit), 32'h1);
      chk("cold_after_load", imemload,  32'h8C22_0004);
      chk("cold_after_iren", 32'(iREN), 32'h0);
      tick();
      chk("repeat_hit_ihit", 32'(ihit), 32'h1);
      chk("repeat_hit_iren", 32'(iREN), 32'h0);
      chk("repeat_hit_load", imemload,  32'h8C22_0004);

      // Conflict: 0x80 shares idx 0 with 0x40.
      imemaddr = 32'h0000_0080;
      #1;
      chk("conflict_miss_ihit", 32'(ihit), 32'h0);
      tick();
      chk("conflict_fill_iaddr", iaddr, 32'h0000_0080);
      iwait = 1'b0;
      iload = 32'h1111_2222;
      tick();
      iwait = 1'b1;
      #1;
      chk("conflict_hit_ihit", 32'(ihit), 32'h1);
      chk("conflict_hit_load", imemload,  32'h1111_2222);
      imemaddr = 32'h0000_0040;
      #1;
      chk("evicted_miss_ihit", 32'(ihit), 32'h0);
      tick();
      chk("evicted_fill_iaddr", iaddr, 32'h0000_0040);
      imemREN = 1'b0;
      #1;
      chk("ren_abort_iren_still", 32'(iREN), 32'h1);
      tick();
      chk("ren_abort_idle_iren", 32'(iREN), 32'h0);
      chk("ren_low_ihit",        32'(ihit), 32'h0);
      tick();
      chk("ren_low_stays_idle", 32'(iREN), 32'h0);
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0080;
      #1;
      chk("abort_kept_frame_ihit", 32'(ihit), 32'h1);
      chk("abort_kept_frame_load", imemload,  32'h1111_2222);

      // Redirect abort: fill for 0x100 redirected to 0x200, even with data ready.
      imemaddr = 32'h0000_0100;
      tick();
      chk("redir_fill_iaddr", iaddr, 32'h0000_0100);
      tick();
      imemaddr = 32'h0000_0200;
      iwait    = 1'b0;
      iload    = 32'hBAD0_BAD0;
      #1;
      chk("redir_cycle_iren",  32'(iREN), 32'h1);
      chk("redir_cycle_iaddr", iaddr,     32'h0000_0100);
      tick();
      iwait = 1'b1;
      #1;
      chk("redir_idle_iren",  32'(iREN), 32'h0);
      chk("redir_no_write",   imemload,  32'h1111_2222);
      chk("redir_new_miss",   32'(ihit), 32'h0);
      tick();
      chk("redir_new_iren",  32'(iREN), 32'h1);
      chk("redir_new_iaddr", iaddr,     32'h0000_0200);
      iwait = 1'b0;
      iload = 32'h2222_3333;
      tick();
      iwait = 1'b1;
      #1;
      chk("redir_new_hit",  32'(ihit), 32'h1);
      chk("redir_new_load", imemload,  32'h2222_3333);

      // Flush: fill 0x4 (idx 1), flush one cycle, then it misses.
      imemaddr = 32'h0000_0004;
      #1;
      chk("flush_pre_miss", 32'(ihit), 32'h0);
      tick();
      chk("flush_fill_iaddr", iaddr, 32'h0000_0004);
      iwait = 1'b0;
      iload = 32'h3333_4444;
      tick();
      iwait = 1'b1;
      #1;
      chk("flush_pre_hit", 32'(ihit), 32'h1);
      flush = 1'b1;
      #1;
      chk("flush_cycle_ihit", 32'(ihit), 32'h0);
      tick();
      flush = 1'b0;
      #1;
      chk("flush_post_miss", 32'(ihit), 32'h0);
      chk("flush_post_iren", 32'(iREN), 32'h0);
      tick();
      chk("flush_refill_iren",  32'(iREN), 32'h1);
      chk("flush_refill_iaddr", iaddr,     32'h0000_0004);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_in_fill_iren", 32'(iREN), 32'h0);

      // Reset during FILL discards the fill and clears the latched address.
      tick();
      chk("rst_mid_fill_iren", 32'(iREN), 32'h1);
      RST = 1'b1;
      tick();
      RST     = 1'b0;
      imemREN = 1'b0;
      #1;
      chk("rst_mid_iren",  32'(iREN), 32'h0);
      chk("rst_mid_iaddr", iaddr,     32'h0);
      chk("rst_mid_ihit",  32'(ihit), 32'h0);
      imemREN = 1'b1;
      imemaddr = 32'h0000_0200;
      #1;
      chk("rst_invalidated", 32'(ihit), 32'h0);
      imemREN = 1'b0;

`ifdef ICACHE_STATS_EN
      RST = 1'b1;
      tick();
      RST      = 1'b0;
      #1;
      chk("stats_rst_hits",   hit_count,  32'h0);
      chk("stats_rst_misses", miss_count, 32'h0);
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0040;
      iwait    = 1'b0;
      iload    = 32'h8C22_0004;
      tick();
      tick();
      iwait = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      imemREN = 1'b0;
      #1;
      chk("stats_hits",   hit_count,  32'd5);
      chk("stats_misses", miss_count, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("stats_flush_keeps_hits", hit_count, 32'd5);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      chk("stats_clr_hits",   hit_count,  32'h0);
      chk("stats_clr_misses", miss_count, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
